overlap_sched: RTL
==================

# overlap_sched

Block-granular scheduler that shares one `overlap` datapath between two channel streams (ch0/ch1) of IMDCT samples. It sits between the IMDCT output stage and the `overlap` instance, driving the `in_overlap_*` interface. Grants are round-robin, one block of `BLOCK_LEN` samples at a time, and each block is tagged with `in_overlap_firstSequence`. It routes `out_overlap_*` results back to per-channel output streams, in issue order.

## Interface
- `DATA_W`, 65: sample width, same as overlap `pcmSample`.
- `BLOCK_LEN`, 18: samples per block, ≥2.
- `TAG_DEPTH`, 4: max blocks in flight inside overlap, power of 2.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `flush`  in  1: single-cycle pulse; marks the next block of both channels as history-restart.
- `ch0_valid`/`ch1_valid`  in  1: request sample valid.
- `ch0_pcmSample`/`ch1_pcmSample`  in  DATA_W: request sample.
- `ch0_ready`/`ch1_ready`  out  1: request sample accepted when valid&ready.
- `in_overlap_valid`, `in_overlap_pcmSample[DATA_W]`, `in_overlap_firstSequence[2]`  out: to overlap.
- `in_overlap_ready`  in  1.
- `out_overlap_valid`, `out_overlap_pcmSample[DATA_W]`  in: from overlap.
- `out_overlap_ready`  out  1.
- `pcm0_valid`/`pcm1_valid`  out  1; `pcm0_sample`/`pcm1_sample`  out  DATA_W; `pcm0_ready`/`pcm1_ready`  in  1.

## Operation
- Issue FSM states:
  - IDLE: if tag FIFO not full and any `chN_valid`, grant the requester. On tie, grant the channel ≠ `last_grant`. Push tag {ch, restart} and go to BURST. Otherwise stay in IDLE.
  - BURST: pass-through. `in_overlap_valid = chG_valid`, `chG_ready = in_overlap_ready`, data muxed from granted channel. The non-granted channel's ready is 0. `icnt` increments per handshake. On the handshake with `icnt==BLOCK_LEN-1`: `icnt←0`, `last_grant←G`, go to IDLE.
- `in_overlap_firstSequence`:
  - bit0 = 1 when `icnt==0`.
  - bit1 = restart flag of the granted channel, held for the whole block.
- Restart flags `rst0`/`rst1`:
  - Set by reset or `flush`.
  - Cleared when the first sample of that channel's block handshakes.
  - `flush` coincident with that handshake: flag stays set and applies to the channel's next block.
- Return path:
  - Tag FIFO head selects destination D. `out_overlap_ready = pcmD_ready & !empty`. `pcmD_valid = out_overlap_valid & !empty`. Other pcm valid = 0. Both pcm sample buses carry `out_overlap_pcmSample`.
  - `ocnt` counts return handshakes. At `BLOCK_LEN-1`, pop FIFO and reset `ocnt`.
- Simultaneous push (IDLE grant) and pop: both take effect; occupancy unchanged. Full is checked on pre-pop occupancy.
- Overlap returns in order, exactly `BLOCK_LEN` outputs per input block.
- Reset values:
  - State IDLE, `icnt`/`ocnt`=0, FIFO empty, `last_grant`=1 (ch0 wins first tie), `rst0`=`rst1`=1.
  - All valids/readies 0. Data outputs 0 when no grant or FIFO empty.
- Reset mid-block discards partial blocks and tags. The overlap instance shares the same reset.

## Timing
- Grant decision takes one cycle in IDLE, so there is exactly one dead cycle between blocks. Max input throughput is `BLOCK_LEN/(BLOCK_LEN+1)`.
- Forward path in BURST is combinational (zero latency), valid→valid and ready→ready.
- Return path is combinational from overlap to pcm ports. Tag/`ocnt` update on the clock edge of each handshake.
- `chN_valid` deasserting mid-burst stalls the burst; it does not end the grant.

## Structure
- `overlap_pkg`:
  - `seq_t` (logic[1:0]) with `SEQ_FIRST_BIT=0`, `SEQ_RESTART_BIT=1`.
  - `tag_t` struct {logic ch; logic restart}.
  - `issue_state_t` enum {IDLE, BURST}.
- Sub-module `overlap_tag_fifo`: synchronous FIFO of `tag_t`, depth `TAG_DEPTH`, with push/pop/full/empty and simultaneous push+pop.

## Test plan
- **Reset state**: only ch0 valid after reset, with `BLOCK_LEN`=18.
  - 18 issued samples carry `firstSequence` 2'b11 then 17×2'b10.
  - Ch0's second block carries 2'b01 then 17×2'b00.
- **Contention**: ch0 and ch1 both valid continuously. Grants alternate ch0, ch1, ch0… with one dead cycle between blocks.
- **Tag back-pressure**: hold `out_overlap_ready` path blocked (`pcm0_ready=pcm1_ready=0`).
  - After 4 blocks issued, FSM stays in IDLE with both chN_ready=0.
  - Releasing `pcm*_ready` resumes issue after the first pop.
- **Return routing**: issue ch1 then ch0 blocks, with overlap model latency 5.
  - First 18 outputs appear only on `pcm1`, next 18 only on `pcm0`.
  - `pcm1_ready=0` stalls `out_overlap_ready`.
- **Flush**:
  - `flush` mid-block of ch0: the remainder of that block keeps bit1=0, and the next ch0 block and next ch1 block start with bit1=1.
  - `flush` on the same cycle as ch0's first-sample handshake: ch0's next block still has bit1=1.
- **Reset mid-burst**: reset at `icnt=7`. Next cycle all valids are 0 and the FIFO is empty, then behaviour matches the reset-state scenario.

Source files
------------

// File: rtl/overlap_pkg.sv
// Shared types for the overlap scheduler: sequence-tag bit positions,
// the in-flight block tag, and the issue FSM state encoding.
package overlap_pkg;

  typedef logic [1:0] seq_t;
  localparam int SEQ_FIRST_BIT   = 0;
  localparam int SEQ_RESTART_BIT = 1;

  typedef struct packed {
    logic ch;
    logic restart;
  } tag_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } issue_state_t;

endpackage

// File: rtl/overlap_tag_fifo.sv
// Synchronous FIFO of block tags (DEPTH must be a power of 2, >= 2).
// Head is read combinationally; push and pop may occur in the same cycle.
module overlap_tag_fifo
  import overlap_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output tag_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  tag_t        mem_q [DEPTH];
  logic        do_push, do_pop;

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + (AW+1)'(do_push);
    rptr_d  = rptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= push_tag;
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/overlap_sched.sv
// Round-robin, block-granular sharing of one overlap datapath between two
// channels; results are routed back per channel using an in-order tag FIFO.
module overlap_sched
  import overlap_pkg::*;
#(
  parameter int DATA_W    = 65,
  parameter int BLOCK_LEN = 18,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ch0_valid,
  input  logic [DATA_W-1:0] ch0_pcmSample,
  output logic              ch0_ready,
  input  logic              ch1_valid,
  input  logic [DATA_W-1:0] ch1_pcmSample,
  output logic              ch1_ready,
  output logic              in_overlap_valid,
  output logic [DATA_W-1:0] in_overlap_pcmSample,
  output logic [1:0]        in_overlap_firstSequence,
  input  logic              in_overlap_ready,
  input  logic              out_overlap_valid,
  input  logic [DATA_W-1:0] out_overlap_pcmSample,
  output logic              out_overlap_ready,
  output logic              pcm0_valid,
  output logic [DATA_W-1:0] pcm0_sample,
  input  logic              pcm0_ready,
  output logic              pcm1_valid,
  output logic [DATA_W-1:0] pcm1_sample,
  input  logic              pcm1_ready
);

  localparam int               CNT_W = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLOCK_LEN - 1);

  issue_state_t     state_q, state_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       rst_q, rst_d;
  logic             blk_restart_q, blk_restart_d;

  logic             burst;
  logic             grant_pick;
  logic             g_valid;
  logic [DATA_W-1:0] g_sample;
  logic             in_hs, first_hs;
  logic             push, pop, full, empty;
  tag_t             push_tag, head;
  logic             dst_ready, out_hs;
  logic             unused_head_restart;

  always_comb begin
    burst      = (state_q == BURST);
    grant_pick = (ch0_valid && ch1_valid) ? ~last_grant_q : ch1_valid;
    g_valid    = grant_q ? ch1_valid : ch0_valid;
    g_sample   = grant_q ? ch1_pcmSample : ch0_pcmSample;
    in_hs      = burst && g_valid && in_overlap_ready;
    first_hs   = in_hs && (icnt_q == '0);
    push       = !burst && !full && (ch0_valid || ch1_valid);
    // A flush in the grant cycle already counts for the block being tagged.
    push_tag.ch      = grant_pick;
    push_tag.restart = rst_q[grant_pick] | flush;
    dst_ready  = head.ch ? pcm1_ready : pcm0_ready;
    out_hs     = out_overlap_valid && !empty && dst_ready;
    pop        = out_hs && (ocnt_q == LAST);
  end

  assign unused_head_restart = head.restart;

  always_comb begin
    state_d       = state_q;
    icnt_d        = icnt_q;
    ocnt_d        = ocnt_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    blk_restart_d = blk_restart_q;
    rst_d         = rst_q;

    case (state_q)
      IDLE: begin
        if (push) begin
          grant_d = grant_pick;
          state_d = BURST;
        end
      end
      BURST: begin
        if (in_hs) begin
          if (icnt_q == LAST) begin
            icnt_d       = '0;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            icnt_d = icnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (first_hs) begin
      blk_restart_d = rst_q[grant_q];
    end

    // Flush wins over the clear, so a coincident flush lands on the next block.
    for (int i = 0; i < 2; i++) begin
      if (first_hs && (grant_q == 1'(i))) rst_d[i] = 1'b0;
      if (flush) rst_d[i] = 1'b1;
    end

    if (out_hs) begin
      ocnt_d = pop ? '0 : ocnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      icnt_q        <= '0;
      ocnt_q        <= '0;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      rst_q         <= 2'b11;
      blk_restart_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      icnt_q        <= icnt_d;
      ocnt_q        <= ocnt_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      rst_q         <= rst_d;
      blk_restart_q <= blk_restart_d;
    end
  end

  overlap_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_tag(push_tag),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    in_overlap_valid         = burst && g_valid;
    in_overlap_pcmSample     = burst ? g_sample : '0;
    in_overlap_firstSequence = '0;
    if (burst) begin
      in_overlap_firstSequence[SEQ_FIRST_BIT]   = (icnt_q == '0);
      in_overlap_firstSequence[SEQ_RESTART_BIT] = (icnt_q == '0) ? rst_q[grant_q] : blk_restart_q;
    end
    ch0_ready         = burst && !grant_q && in_overlap_ready;
    ch1_ready         = burst && grant_q && in_overlap_ready;
    out_overlap_ready = !empty && dst_ready;
    pcm0_valid        = out_overlap_valid && !empty && !head.ch;
    pcm1_valid        = out_overlap_valid && !empty && head.ch;
    pcm0_sample       = empty ? '0 : out_overlap_pcmSample;
    pcm1_sample       = empty ? '0 : out_overlap_pcmSample;
  end

endmodule
